// File: rtl/cordic_arbiter.sv
// Round-robin front end for one shared fixed-latency CORDIC rotator: credit-gated
// grants, a requester-tag pipeline matching the rotator latency, per-requester FIFOs.
module cordic_arbiter #(
  parameter int N_REQ   = 4,
  parameter int D_WIDTH = 7,
  parameter int OUT_W   = D_WIDTH + 1,
  parameter int LATENCY = 6,
  parameter int DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*D_WIDTH-1:0] req_angle,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [N_REQ*OUT_W-1:0]   rsp_x,
  output logic [N_REQ*OUT_W-1:0]   rsp_y,
  input  logic [N_REQ-1:0]         rsp_ready,
  output logic [D_WIDTH-1:0]       cor_z_tgt,
  input  logic [OUT_W-1:0]         cor_x_in,
  input  logic [OUT_W-1:0]         cor_y_in,
  output logic                     busy
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int CR_W = $clog2(DEPTH + 1);
  localparam int AW   = $clog2(DEPTH);

  logic [ID_W-1:0]    r_rr;
  logic [CR_W-1:0]    r_cred   [N_REQ];
  logic [D_WIDTH-1:0] r_z_tgt;
  logic [LATENCY:0]   r_tag_v;
  logic [ID_W-1:0]    r_tag_id [LATENCY+1];
  logic [OUT_W-1:0]   r_mem_x  [N_REQ][DEPTH];
  logic [OUT_W-1:0]   r_mem_y  [N_REQ][DEPTH];
  logic [AW:0]        r_wr     [N_REQ];
  logic [AW:0]        r_rd     [N_REQ];

  logic [D_WIDTH-1:0] w_angle  [N_REQ];
  logic [N_REQ-1:0]   w_elig;
  logic [N_REQ-1:0]   w_grant;
  logic [N_REQ-1:0]   w_push;
  logic [N_REQ-1:0]   w_pop;
  logic [N_REQ-1:0]   w_nonempty;
  logic               w_any_grant;
  logic [ID_W-1:0]    w_win;
  logic [ID_W-1:0]    w_cand;
  logic [ID_W-1:0]    w_rr_next;

  // A requester is eligible only while it still holds a free slot in its FIFO,
  // counting results already in flight through the rotator.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_angle    = '{default: '0};
    w_elig     = '0;
    w_nonempty = '0;
    w_push     = '0;
    w_pop      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_angle[i]    = req_angle[i*D_WIDTH +: D_WIDTH];
      w_elig[i]     = rst_n & req_valid[i] & (r_cred[i] < CR_W'(DEPTH));
      w_nonempty[i] = rst_n & (r_wr[i] != r_rd[i]);
      w_push[i]     = r_tag_v[LATENCY] & (r_tag_id[LATENCY] == ID_W'(i));
      w_pop[i]      = w_nonempty[i] & rsp_ready[i];
    end
  end

  always_comb begin
    w_any_grant = 1'b0;
    w_win       = '0;
    w_cand      = '0;
    w_grant     = '0;
    // NOTE: blocking '=' here so the found flag set in one iteration is seen by the next.
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = ID_W'((int'(r_rr) + k) % N_REQ);
      if (!w_any_grant && w_elig[w_cand]) begin
        w_any_grant = 1'b1;
        w_win       = w_cand;
      end
    end
    if (w_any_grant) w_grant[w_win] = 1'b1;
    w_rr_next = (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    if (!rst_n) begin
      r_rr    <= '0;
      r_z_tgt <= '0;
      r_tag_v <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        r_cred[i] <= '0;
        r_wr[i]   <= '0;
        r_rd[i]   <= '0;
      end
    end else begin
      r_tag_v <= {r_tag_v[LATENCY-1:0], w_any_grant};
      if (w_any_grant) begin
        r_rr    <= w_rr_next;
        r_z_tgt <= w_angle[w_win];
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (w_push[i]) r_wr[i] <= r_wr[i] + 1'b1;
        if (w_pop[i])  r_rd[i] <= r_rd[i] + 1'b1;
        if (w_grant[i] && !w_pop[i])      r_cred[i] <= r_cred[i] + 1'b1;
        else if (!w_grant[i] && w_pop[i]) r_cred[i] <= r_cred[i] - 1'b1;
      end
    end
  end

  // NOTE: tag ids and FIFO storage carry no reset; the tag valids and FIFO pointers qualify them.
  always_ff @(posedge clk) begin
    r_tag_id[0] <= w_win;
    for (int k = 1; k <= LATENCY; k++) r_tag_id[k] <= r_tag_id[k-1];
    for (int i = 0; i < N_REQ; i++) begin
      if (w_push[i]) begin
        r_mem_x[i][r_wr[i][AW-1:0]] <= cor_x_in;
        r_mem_y[i][r_wr[i][AW-1:0]] <= cor_y_in;
      end
    end
  end

  always_comb begin
    rsp_x = '0;
    rsp_y = '0;
    busy  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rst_n) begin
        rsp_x[i*OUT_W +: OUT_W] = r_mem_x[i][r_rd[i][AW-1:0]];
        rsp_y[i*OUT_W +: OUT_W] = r_mem_y[i][r_rd[i][AW-1:0]];
        if (r_cred[i] != '0) busy = 1'b1;
      end
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = w_nonempty;
  assign cor_z_tgt = r_z_tgt;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Randomized bench for cordic_arbiter: a behavioural rotator plus a queue-based
// reference model of grants, credits and per-requester response ordering.
module tb_cordic_arbiter;

  localparam int  N     = 4;
  localparam int  DW    = 7;
  localparam int  OW    = DW + 1;
  localparam int  LAT   = 6;
  localparam int  DEPTH = 8;
  localparam real PI    = 3.14159265358979;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*DW-1:0] req_angle;
  logic [N*OW-1:0] rsp_x, rsp_y;
  logic [DW-1:0]   cor_z_tgt;
  logic [OW-1:0]   cor_x_in, cor_y_in;
  logic            busy;

  always #5 clk = ~clk;

  cordic_arbiter #(.N_REQ(N), .D_WIDTH(DW), .OUT_W(OW), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_ready(rsp_ready),
    .cor_z_tgt(cor_z_tgt), .cor_x_in(cor_x_in), .cor_y_in(cor_y_in),
    .busy(busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural rotator: round(64*cos), round(64*sin) of angle*PI/128, LAT cycles late.
  int cos_tab [1<<DW];
  int sin_tab [1<<DW];
  initial begin
    for (int a = 0; a < (1 << DW); a++) begin
      cos_tab[a] = $rtoi($floor(64.0 * $cos(PI * real'(a) / 128.0) + 0.5));
      sin_tab[a] = $rtoi($floor(64.0 * $sin(PI * real'(a) / 128.0) + 0.5));
    end
  end

  logic [DW-1:0] zpipe [LAT-1];
  always @(posedge clk) begin
    zpipe[0] <= cor_z_tgt;
    for (int k = 1; k < LAT - 1; k++) zpipe[k] <= zpipe[k-1];
    cor_x_in <= OW'(cos_tab[zpipe[LAT-2]]);
    cor_y_in <= OW'(sin_tab[zpipe[LAT-2]]);
  end

  // Reference model: one queue per requester holds every granted-but-unpopped angle
  // (its length is the credit count) with the cycle its result becomes visible.
  typedef struct {
    logic [DW-1:0] ang;
    int            avail;
  } ent_t;

  ent_t         m_q [N][$];
  int           m_rr = 0;
  int           cyc  = 0;
  logic [N-1:0] acc  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : model
    logic [N-1:0]  exp_rdy, exp_vld;
    logic [OW-1:0] ex_x, ex_y;
    logic          exp_busy;
    ent_t          e;
    int            w, idx;
    if (!rst_n) begin
      check("rst_ready", 64'(req_ready), 64'(0));
      check("rst_valid", 64'(rsp_valid), 64'(0));
      check("rst_busy",  64'(busy), 64'(0));
      check("rst_x",     64'(rsp_x), 64'(0));
      check("rst_y",     64'(rsp_y), 64'(0));
      for (int i = 0; i < N; i++) m_q[i].delete();
      m_rr = 0;
      acc  = '0;
    end else begin
      exp_rdy = '0;
      w = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (w < 0 && req_valid[idx] && m_q[idx].size() < DEPTH) w = idx;
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
      check("grant", 64'(req_ready), 64'(exp_rdy));

      exp_vld  = '0;
      exp_busy = 1'b0;
      for (int i = 0; i < N; i++) begin
        exp_vld[i] = (m_q[i].size() > 0) && (m_q[i][0].avail <= cyc);
        if (m_q[i].size() > 0) exp_busy = 1'b1;
      end
      check("rsp_valid", 64'(rsp_valid), 64'(exp_vld));
      check("busy", 64'(busy), 64'(exp_busy));
      for (int i = 0; i < N; i++) begin
        if (exp_vld[i] && rsp_valid[i]) begin
          ex_x = OW'(cos_tab[m_q[i][0].ang]);
          ex_y = OW'(sin_tab[m_q[i][0].ang]);
          check($sformatf("rsp_x%0d", i), 64'(rsp_x[i*OW +: OW]), 64'(ex_x));
          check($sformatf("rsp_y%0d", i), 64'(rsp_y[i*OW +: OW]), 64'(ex_y));
        end
      end

      acc = req_valid & req_ready;
      if (w >= 0) begin
        e.ang   = req_angle[w*DW +: DW];
        e.avail = cyc + LAT + 2;
        m_q[w].push_back(e);
        m_rr = (w + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (exp_vld[i] && rsp_ready[i]) void'(m_q[i].pop_front());
    end
  end

  // Driver: a request stays pending (valid, angle stable) until it is accepted.
  logic [N-1:0]  pend;
  logic [DW-1:0] ang [N];

  task automatic drive();
    req_valid = pend;
    for (int i = 0; i < N; i++) req_angle[i*DW +: DW] = ang[i];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pend = pend & ~acc;
  endtask

  task automatic single_shot(input logic [DW-1:0] a, input int ex_x, input int ex_y);
    int lat;
    pend[0] = 1'b1;
    ang[0]  = a;
    drive();
    step();
    drive();
    check("single_acc", 64'(acc[0]), 64'(1));
    lat = 0;
    while (!rsp_valid[0] && lat < 20) begin
      step();
      drive();
      lat++;
    end
    check("single_lat", 64'(lat + 1), 64'(LAT + 2));
    check("single_x", 64'(rsp_x[OW-1:0]), 64'(OW'(ex_x)));
    check("single_y", 64'(rsp_y[OW-1:0]), 64'(OW'(ex_y)));
    repeat (3) step();
    check("single_busy", 64'(busy), 64'(0));
  endtask

  task automatic fill_all();
    for (int i = 0; i < N; i++)
      if (!pend[i]) begin
        pend[i] = 1'b1;
        ang[i]  = DW'($urandom);
      end
  endtask

  initial begin
    int nxt, cnt;
    rst_n     = 1'b0;
    pend      = '0;
    rsp_ready = '0;
    for (int i = 0; i < N; i++) ang[i] = '0;
    drive();
    repeat (3) step();
    rst_n = 1'b1;

    // single requester, quarter-turn boundaries
    rsp_ready = '1;
    repeat (2) step();
    single_shot(7'd0, 64, 0);
    single_shot(7'd64, 0, 64);

    // fairness: everyone requesting continuously
    repeat (40) begin
      fill_all();
      drive();
      step();
    end
    pend = '0;
    drive();
    repeat (12) step();

    // backpressure on requester 2 streaming angles 0..15
    rsp_ready = 4'b1011;
    nxt = 0;
    cnt = 0;
    repeat (20) begin
      if (!pend[2] && nxt < 16) begin
        pend[2] = 1'b1;
        ang[2]  = DW'(nxt);
        nxt++;
      end
      drive();
      step();
      if (acc[2]) cnt++;
    end
    check("bp_accepts", 64'(cnt), 64'(DEPTH));
    check("bp_stall", 64'(req_ready[2]), 64'(0));
    rsp_ready[2] = 1'b1;
    step();
    rsp_ready[2] = 1'b0;
    check("bp_regrant", 64'(req_ready[2]), 64'(1));
    step();
    rsp_ready[2] = 1'b1;
    for (int k = 0; k < 100 && (nxt < 16 || pend[2]); k++) begin
      if (!pend[2] && nxt < 16) begin
        pend[2] = 1'b1;
        ang[2]  = DW'(nxt);
        nxt++;
      end
      drive();
      step();
    end
    check("bp_all_sent", 64'(pend[2]), 64'(0));
    pend = '0;
    drive();
    repeat (12) step();

    // reset with results in flight
    rsp_ready = '0;
    repeat (5) begin
      fill_all();
      drive();
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    pend  = '0;
    drive();
    rsp_ready = '1;
    repeat (15) step();
    check("rstmid_valid", 64'(rsp_valid), 64'(0));
    check("rstmid_busy", 64'(busy), 64'(0));
    pend = '1;
    drive();
    #1;
    check("rstmid_rr", 64'(req_ready), 64'(1));
    step();
    pend = '0;
    drive();
    repeat (12) step();

    // only requesters 1 and 3, random gaps and random pops
    repeat (300) begin
      for (int i = 1; i < N; i += 2)
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          ang[i]  = DW'($urandom);
        end
      rsp_ready = N'($urandom);
      drive();
      step();
    end

    // everything random, with occasional resets
    repeat (1500) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 0) begin
          pend[i] = 1'b1;
          ang[i]  = DW'($urandom);
        end
      rsp_ready = N'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      drive();
      step();
    end
    rst_n = 1'b1;

    pend      = '0;
    rsp_ready = '1;
    drive();
    for (int k = 0; k < 60 && (busy || rsp_valid != '0); k++) step();
    repeat (2) step();
    check("drain_busy", 64'(busy), 64'(0));
    check("drain_valid", 64'(rsp_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
